key_debouncer: RTL and testbench

- Input conditioning stage for the board push-buttons, sitting directly upstream of the key-press edge filter.
- Synchronises each raw asynchronous KEY pin into the system clock domain and normalises polarity so 1 = pressed.
- Rejects contact bounce by requiring a stable level for a fixed number of cycles.
- Outputs clean, glitch-free level signals; the downstream filter turns each into a one-cycle press pulse.

---
 rtl/flappy_pkg.sv | 24 ++
 rtl/key_debounce_lane.sv | 83 ++++++++
 rtl/key_debouncer.sv | 32 +++
 tb/tb_key_debouncer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flappy_pkg: shared key-debounce state encoding and timing constants   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package flappy_pkg;

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   typedef enum logic [1:0] {
      RELEASED     = ST_RELEASED,
      PRESS_WAIT   = ST_PRESS_WAIT,
      PRESSED      = ST_PRESSED,
      RELEASE_WAIT = ST_RELEASE_WAIT
   } key_state_t;

   // 10 ms of stability at the 50 MHz system clock
   localparam int DEBOUNCE_CYCLES_50MHZ = 500000;

endpackage
`default_nettype wire

// File: rtl/key_debounce_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce_lane: two-flop synchroniser plus debounce FSM, one key   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module key_debounce_lane
   import flappy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_out
);

   localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             sample;
   key_state_t       state;
   logic [CNT_W-1:0] cnt;

   assign sample = sync2 ^ ACTIVE_LOW;

   // key_out only moves on the two accepting transitions, so it tracks
   // PRESSED/RELEASE_WAIT without a separate decode stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= ACTIVE_LOW;
         sync2   <= ACTIVE_LOW;
         state   <= RELEASED;
         cnt     <= '0;
         key_out <= 1'b0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         case (state)
            RELEASED: begin
               if (sample) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sample) begin
                  state <= RELEASED;
               end else if (cnt == CNT_LAST) begin
                  state   <= PRESSED;
                  key_out <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!sample) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (sample) begin
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state   <= RELEASED;
                  key_out <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= RELEASED;
               key_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debouncer: NUM_KEYS independent synchronise-and-debounce lanes    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module key_debouncer
   import flappy_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_out
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
      key_debounce_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .key_raw (key_raw[i]),
         .key_out (key_out[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_debouncer: directed scoreboard bench, DEBOUNCE_CYCLES = 4      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_key_debouncer;

   localparam int NK = 4;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_raw;
   logic [NK-1:0] key_out;

   int checks = 0;
   int errors = 0;

   logic [NK-1:0] exp_q[$];
   logic [NK-1:0] m_s1, m_s2, m_out;
   int            m_run[NK];

   key_debouncer #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (D),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .key_raw (key_raw),
      .key_out (key_out)
   );

   always #5 clk = ~clk;

   // Reference: the output flips once the synchronised level has disagreed
   // with it for D+1 consecutive edges.
   task automatic model_edge();
      logic [NK-1:0] e;
      if (reset) begin
         m_s1  = '1;
         m_s2  = '1;
         m_out = '0;
         for (int i = 0; i < NK; i++) m_run[i] = 0;
      end else begin
         for (int i = 0; i < NK; i++) begin
            if ((~m_s2[i]) != m_out[i]) begin
               m_run[i]++;
               if (m_run[i] == D + 1) begin
                  m_out[i] = ~m_out[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = key_raw;
      end
      e = m_out;
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
   endtask

   // One clock: drive at the falling edge, model the rising edge, compare 1 ns later.
   task automatic step(input logic rst, input logic [NK-1:0] raw);
      logic [NK-1:0] e;
      @(negedge clk);
      reset   = rst;
      key_raw = raw;
      @(posedge clk);
      model_edge();
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", key_out, 'x);
      end else begin
         e = exp_q.pop_front();
         check("scoreboard", key_out, e);
      end
   endtask

   task automatic steps(input int n, input logic rst, input logic [NK-1:0] raw);
      for (int k = 0; k < n; k++) step(rst, raw);
   endtask

   initial begin
      reset   = 1'b1;
      key_raw = 4'b0000;
      m_s1 = '1; m_s2 = '1; m_out = '0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;

      // Reset value with all keys held
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 4'b0000);
         check("reset_value", key_out, 4'b0000);
      end
      steps(4, 1'b0, 4'b1111);

      // Clean press and release on lane 0
      steps(6, 1'b0, 4'b1110);
      check("press0_edge6", key_out, 4'b0000);
      step(1'b0, 4'b1110);
      check("press0_edge7", key_out, 4'b0001);
      steps(12, 1'b0, 4'b1110);
      steps(6, 1'b0, 4'b1111);
      check("release0_edge6", key_out, 4'b0001);
      step(1'b0, 4'b1111);
      check("release0_edge7", key_out, 4'b0000);
      steps(2, 1'b0, 4'b1111);

      // Press bounce on lane 1: 3-cycle glitches never reach the output
      for (int r = 0; r < 3; r++) begin
         steps(3, 1'b0, 4'b1101);
         check("bounce1_low", key_out, 4'b0000);
         steps(3, 1'b0, 4'b1111);
         check("bounce1_high", key_out, 4'b0000);
      end
      steps(6, 1'b0, 4'b1101);
      check("press1_edge6", key_out, 4'b0000);
      step(1'b0, 4'b1101);
      check("press1_edge7", key_out, 4'b0010);
      steps(8, 1'b0, 4'b1111);
      check("release1", key_out, 4'b0000);

      // Release bounce on lane 2 leaves the output high
      steps(8, 1'b0, 4'b1011);
      check("press2", key_out, 4'b0100);
      steps(2, 1'b0, 4'b1111);
      check("rbounce2_a", key_out, 4'b0100);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 4'b1011);
         check("rbounce2_hold", key_out, 4'b0100);
      end
      steps(8, 1'b0, 4'b1111);
      check("release2", key_out, 4'b0000);

      // Simultaneous press on every lane
      steps(6, 1'b0, 4'b0000);
      check("simul_edge6", key_out, 4'b0000);
      step(1'b0, 4'b0000);
      check("simul_edge7", key_out, 4'b1111);
      steps(3, 1'b0, 4'b0000);

      // Reset while held, then re-debounce
      step(1'b1, 4'b0000);
      check("reset_mid", key_out, 4'b0000);
      steps(6, 1'b0, 4'b0000);
      check("post_reset_edge6", key_out, 4'b0000);
      step(1'b0, 4'b0000);
      check("post_reset_edge7", key_out, 4'b1111);
      steps(10, 1'b0, 4'b1111);
      check("final_release", key_out, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
